// File: rtl/instr_loader.sv
// Framed byte-stream loader: assembles little-endian words into instruction memory, holding the CPU during a frame.
// Write lands 1 cycle after each 4th data byte; rx_ready is low only in the FIN cycle and in the reset cycle.
module instr_loader #(
    parameter int          ADDR_W = 8,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic              ok_q, ok_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;

    logic        accept;
    logic [16:0] len_full;
    logic [16:0] wcnt_next;

    assign rx_ready  = ~rst & (state_q != S_FIN);
    assign accept    = rx_valid & rx_ready;
    assign len_full  = {1'b0, rx_data, len_q[7:0]};
    assign wcnt_next = 17'(wcnt_q) + 17'd1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        bidx_d     = bidx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        ok_d       = ok_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept && rx_data == MAGIC) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    wcnt_d      = '0;
                    bidx_d      = '0;
                    csum_d      = '0;
                    // Bounding N here is what keeps the word address from ever wrapping.
                    if (len_full > MAX_WORDS) begin
                        ok_d    = 1'b0;
                        state_d = S_FIN;
                    end else if (len_full == 17'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    word_d = {rx_data, word_q[23:8]};
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = wcnt_q[ADDR_W-1:0];
                        im_wdata_d = {rx_data, word_q};
                        wcnt_d     = wcnt_q + 1'b1;
                        if (wcnt_next == {1'b0, len_q}) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    ok_d    = (rx_data == csum_q);
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            wcnt_q     <= '0;
            bidx_q     <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            ok_q       <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            bidx_q     <= bidx_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            ok_q       <= ok_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
        end
    end

    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign cpu_hold  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CSUM);
    assign load_done = (state_q == S_FIN) & ok_q;
    assign load_err  = (state_q == S_FIN) & ~ok_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: frame-level reference model checked every cycle, plus literal write/pulse checks per scenario.
module tb_instr_loader;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       im_we;
    logic [7:0] im_addr;
    logic [31:0] im_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    instr_loader #(.ADDR_W(8), .MAGIC(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the bytes of the current frame are kept in a queue and outcomes
    // are derived from the frame's position arithmetic, not from a state machine.
    logic [7:0]  fr[$];
    logic        model_on = 1'b0;
    logic        exp_we, exp_hold, exp_done, exp_err;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata;

    initial begin
        int sz, n, k;
        logic [7:0] x;
        logic acc;
        exp_we = 0; exp_hold = 0; exp_done = 0; exp_err = 0; exp_addr = 0; exp_wdata = 0;
        forever begin
            @(posedge clk);
            model_on = 1'b1;
            if (rst) begin
                fr.delete();
                exp_we = 0; exp_hold = 0; exp_done = 0; exp_err = 0;
                exp_addr = 0; exp_wdata = 0;
            end else begin
                acc = rx_valid && !(exp_done || exp_err);
                exp_we = 0; exp_done = 0; exp_err = 0;
                if (acc) begin
                    if (fr.size() == 0) begin
                        if (rx_data == 8'hA5) fr.push_back(rx_data);
                    end else begin
                        fr.push_back(rx_data);
                        sz = fr.size();
                        if (sz >= 3) begin
                            n = 32'({fr[2], fr[1]});
                            k = sz - 3;
                            if (sz == 3 && n > 256) begin
                                exp_err = 1;
                                fr.delete();
                            end else if (k >= 1 && k <= 4 * n && k % 4 == 0) begin
                                exp_we    = 1;
                                exp_addr  = 8'(k / 4 - 1);
                                exp_wdata = {fr[sz-1], fr[sz-2], fr[sz-3], fr[sz-4]};
                            end else if (k == 4 * n + 1) begin
                                x = 8'h00;
                                for (int i = 3; i <= sz - 2; i++) x = x ^ fr[i];
                                if (fr[sz-1] == x) exp_done = 1;
                                else               exp_err  = 1;
                                fr.delete();
                            end
                        end
                    end
                end
                exp_hold = (fr.size() != 0);
            end
        end
    end

    // Per-cycle compare and write/pulse log, both at the falling edge.
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int n_done = 0;
    int n_err  = 0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("rx_ready",  32'(rx_ready),  32'(!rst && !(exp_done || exp_err)));
            chk("im_we",     32'(im_we),     32'(exp_we));
            chk("im_addr",   32'(im_addr),   32'(exp_addr));
            chk("im_wdata",  im_wdata,       exp_wdata);
            chk("cpu_hold",  32'(cpu_hold),  32'(exp_hold));
            chk("load_done", 32'(load_done), 32'(exp_done));
            chk("load_err",  32'(load_err),  32'(exp_err));
        end
        if (im_we === 1'b1) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
        if (load_done === 1'b1) n_done++;
        if (load_err === 1'b1)  n_err++;
    end

    function automatic logic [31:0] get_data(input int i);
        return (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] get_addr(input int i);
        return (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] txq[$];

    task automatic send_q(input bit gap);
        logic r;
        int tries;
        foreach (txq[i]) begin
            rx_valid = 1'b1;
            rx_data  = txq[i];
            tries    = 0;
            r        = 1'b0;
            while (!r && tries < 20) begin
                @(negedge clk);
                r = rx_ready;
                @(posedge clk);
                #1;
                tries++;
            end
            rx_valid = 1'b0;
            if (!r) chk("send_timeout", 32'(r), 32'd1);
            if (gap) idle(1);
        end
    endtask

    task automatic check_good_log(input string tag);
        chk({tag, "_nwr"},   32'(wr_data.size()), 32'd2);
        chk({tag, "_a0"},    get_addr(0), 32'd0);
        chk({tag, "_d0"},    get_data(0), 32'h0050_0093);
        chk({tag, "_a1"},    get_addr(1), 32'd1);
        chk({tag, "_d1"},    get_data(1), 32'h0010_0113);
        chk({tag, "_done"},  32'(n_done), 32'd1);
        chk({tag, "_err"},   32'(n_err),  32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hold",  32'(cpu_hold), 32'd0);
        chk("rst_rdy",   32'(rx_ready), 32'd1);
        chk("rst_addr",  32'(im_addr),  32'd0);
        chk("rst_wdata", im_wdata,      32'd0);
        chk("rst_we",    32'(im_we),    32'd0);
        @(posedge clk);
        #1;

        // Good image, back to back
        clear_log();
        txq = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        send_q(1'b0);
        idle(3);
        check_good_log("good");

        // Bad checksum
        clear_log();
        txq = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC0};
        send_q(1'b0);
        idle(3);
        chk("badcs_nwr",  32'(wr_data.size()), 32'd2);
        chk("badcs_done", 32'(n_done), 32'd0);
        chk("badcs_err",  32'(n_err),  32'd1);

        // Junk then a good frame
        clear_log();
        txq = '{8'h00, 8'hFF, 8'h12};
        send_q(1'b0);
        idle(1);
        chk("junk_hold", 32'(cpu_hold), 32'd0);
        chk("junk_nwr",  32'(wr_data.size()), 32'd0);
        txq = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        send_q(1'b0);
        idle(3);
        check_good_log("junkgood");

        // Empty image
        clear_log();
        txq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q(1'b0);
        idle(3);
        chk("empty_nwr",  32'(wr_data.size()), 32'd0);
        chk("empty_done", 32'(n_done), 32'd1);
        chk("empty_err",  32'(n_err),  32'd0);

        // Oversize N=257
        clear_log();
        txq = '{8'hA5, 8'h01, 8'h01};
        send_q(1'b0);
        @(negedge clk);
        chk("over_err_now", 32'(load_err), 32'd1);
        @(posedge clk);
        #1;
        idle(2);
        chk("over_nwr",  32'(wr_data.size()), 32'd0);
        chk("over_done", 32'(n_done), 32'd0);
        chk("over_err",  32'(n_err),  32'd1);

        // Reset after the 6th data byte
        clear_log();
        txq = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
        send_q(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_hold", 32'(cpu_hold), 32'd0);
        @(posedge clk);
        #1;
        idle(2);
        chk("mrst_nwr", 32'(wr_data.size()), 32'd1);
        chk("mrst_a0",  get_addr(0), 32'd0);
        chk("mrst_err", 32'(n_err),  32'd0);
        clear_log();
        txq = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        send_q(1'b0);
        idle(3);
        check_good_log("postrst");

        // Throttled input
        clear_log();
        send_q(1'b1);
        idle(3);
        check_good_log("throttle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
